// File: rtl/my_arith_pkg.sv
// Shared arithmetic-library types and helpers.
// Used by the serial subtractor and its full-subtractor cell.
package my_arith_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sub_state_t;

    // Counter width for counting 0..w-1, never narrower than one bit.
    function automatic int cnt_width(input int w);
        if (w <= 1) begin
            return 1;
        end
        return $clog2(w);
    endfunction

endpackage

// File: rtl/my_full_subtractor.sv
// Combinational one-bit full subtractor: a - b - borrow_in.
// Produces the difference bit and the borrow out of this position.
module my_full_subtractor (
    output logic diff,
    output logic borrow_out,
    input  logic a,
    input  logic b,
    input  logic borrow_in
);

    assign diff       = a ^ b ^ borrow_in;
    assign borrow_out = (~a & b) | (~(a ^ b) & borrow_in);

endmodule

// File: rtl/my_serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor, LSB first, one full-subtractor cell.
// Start/done handshake; results are held until the next completed run.
module my_serial_subtractor
    import my_arith_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
);

    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    sub_state_t       state_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] a_sh_q;
    logic [WIDTH-1:0] b_sh_q;
    logic [WIDTH-1:0] res_q;
    logic [WIDTH-1:0] res_d;
    logic             brw_q;
    logic [WIDTH-1:0] diff_q;
    logic             borrow_q;
    logic             done_q;

    logic cell_diff;
    logic cell_bout;

    my_full_subtractor u_cell (
        .diff       (cell_diff),
        .borrow_out (cell_bout),
        .a          (a_sh_q[0]),
        .b          (b_sh_q[0]),
        .borrow_in  (brw_q)
    );

    // Each new difference bit enters at the MSB, so after WIDTH
    // shifts bit 0 of the operands has landed at bit 0 of the result.
    generate
        if (WIDTH == 1) begin : g_res_1
            assign res_d = cell_diff;
        end else begin : g_res_n
            assign res_d = {cell_diff, res_q[WIDTH-1:1]};
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            res_q    <= '0;
            brw_q    <= 1'b0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        a_sh_q  <= a;
                        b_sh_q  <= b;
                        brw_q   <= 1'b0;
                        cnt_q   <= '0;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    res_q  <= res_d;
                    a_sh_q <= a_sh_q >> 1;
                    b_sh_q <= b_sh_q >> 1;
                    brw_q  <= cell_bout;
                    cnt_q  <= cnt_q + CW'(1);
                    if (cnt_q == LAST) begin
                        diff_q   <= res_d;
                        borrow_q <= cell_bout;
                        done_q   <= 1'b1;
                        state_q  <= DONE;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy   = (state_q != IDLE);
    assign done   = done_q;
    assign diff   = diff_q;
    assign borrow = borrow_q;

endmodule

// File: tb/tb_my_serial_subtractor.sv
// Scoreboard bench for my_serial_subtractor at WIDTH=4.
// Driver queues expected results; a negedge monitor checks them.
module tb_my_serial_subtractor;

    localparam int W = 4;

    typedef struct {
        logic [W-1:0] d;
        logic         br;
        int           cyc;
    } exp_t;

    logic         clk;
    logic         reset;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         borrow;

    my_serial_subtractor #(.WIDTH(W)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .diff   (diff),
        .borrow (borrow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;
    bit   fin = 0;
    bit   expect_idle = 0;
    bit   sweep_on = 0;

    logic [W-1:0] hold_d = '0;
    logic         hold_b = 1'b0;
    logic         prev_done = 1'b0;
    bit           prev_sweep = 0;
    int           last_done = 0;

    always @(negedge clk) begin
        exp_t e;
        if (fin) begin
            n_vec++;
            if (exp_q.size() != 0) begin
                n_err++;
                $display("FAIL drain: %0d results outstanding, want 0",
                         exp_q.size());
            end
            $display("== %0d vectors applied, %0d miscompares ==",
                     n_vec, n_err);
            $finish;
        end else if (reset) begin
            n_vec++;
            if ({busy, done, diff, borrow} !== '0) begin
                n_err++;
                $display("FAIL reset_outs: busy=%b done=%b diff=%h brw=%b want 0",
                         busy, done, diff, borrow);
            end
            hold_d    = '0;
            hold_b    = 1'b0;
            prev_done = 1'b0;
        end else begin
            if (done) begin
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL spurious_done: done=1 at cyc %0d, want none",
                             cyc);
                end else begin
                    e = exp_q.pop_front();
                    n_vec++;
                    if (diff !== e.d || borrow !== e.br) begin
                        n_err++;
                        $display("FAIL result: got %b/%h want %b/%h",
                                 borrow, diff, e.br, e.d);
                    end
                    n_vec++;
                    if (cyc != e.cyc) begin
                        n_err++;
                        $display("FAIL done_time: got cyc %0d want %0d",
                                 cyc, e.cyc);
                    end
                    hold_d = e.d;
                    hold_b = e.br;
                end
                n_vec++;
                if (busy !== 1'b1) begin
                    n_err++;
                    $display("FAIL busy_at_done: got %b want 1", busy);
                end
                n_vec++;
                if (prev_done) begin
                    n_err++;
                    $display("FAIL done_pulse: done high 2 cycles, want 1");
                end
                if (sweep_on && prev_sweep) begin
                    n_vec++;
                    if (cyc - last_done != W + 2) begin
                        n_err++;
                        $display("FAIL spacing: got %0d want %0d",
                                 cyc - last_done, W + 2);
                    end
                end
                prev_sweep = sweep_on;
                last_done  = cyc;
            end else begin
                n_vec++;
                if (diff !== hold_d || borrow !== hold_b) begin
                    n_err++;
                    $display("FAIL hold: got %b/%h want %b/%h",
                             borrow, diff, hold_b, hold_d);
                end
                if (expect_idle) begin
                    n_vec++;
                    if (busy !== 1'b0) begin
                        n_err++;
                        $display("FAIL idle_busy: got %b want 0", busy);
                    end
                end
            end
            prev_done = done;
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (busy === 1'b1 && n < 64) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic issue(input logic [W-1:0] ia,
                         input logic [W-1:0] ib,
                         input bit push);
        exp_t        e;
        logic [W:0]  r;
        wait_idle();
        r     = {1'b0, ia} - {1'b0, ib};
        a     = ia;
        b     = ib;
        start = 1'b1;
        if (push) begin
            e.d   = r[W-1:0];
            e.br  = r[W];
            e.cyc = cyc + 1 + W;
            exp_q.push_back(e);
        end
        @(negedge clk);
        start = 1'b0;
        a     = W'($urandom);
        b     = W'($urandom);
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        expect_idle = 1;
        repeat (5) @(negedge clk);
        expect_idle = 0;

        issue(4'd9, 4'd3, 1);
        repeat (8) @(negedge clk);
        issue(4'd3, 4'd9, 1);
        issue(4'd0, 4'd0, 1);
        issue(4'd15, 4'd15, 1);
        issue(4'd0, 4'd1, 1);

        issue(4'd9, 4'd3, 1);
        start = 1'b1;
        a     = 4'd1;
        b     = 4'd1;
        @(negedge clk);
        start = 1'b0;

        issue(4'd5, 4'd12, 0);
        repeat (2) @(negedge clk);
        @(posedge clk);
        #2 reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (8) @(negedge clk);
        issue(4'd7, 4'd2, 1);

        wait_idle();
        sweep_on = 1;
        for (int i = 0; i < 256; i++) begin
            issue(W'(i >> 4), W'(i & 15), 1);
        end
        wait_idle();
        sweep_on = 0;

        for (int k = 0; k < 40; k++) begin
            issue(W'($urandom), W'($urandom), 1);
            if ($urandom_range(0, 1) == 1) begin
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
            end
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        wait_idle();
        repeat (3) @(negedge clk);
        fin = 1;
        repeat (4) @(negedge clk);
        $fatal(1, "FAIL monitor: summary not reached");
    end

endmodule
